ahb3lite_interconnect_slave_arbiter: RTL and testbench

- Per-slave-port arbiter, directly downstream of the slave priority tree.
- Takes the tree's winning priority level plus per-master HSEL/priority/transfer state and issues a registered one-hot grant.
- Uses round-robin among masters tied at the highest priority level.
- Holds ownership across bursts, locked sequences and wait states, and tracks which master owns the current data phase for response and read-data routing.

---
 rtl/ahb3lite_interconnect_slave_arbiter.sv | 123 ++++++++++++
 tb/tb_ahb3lite_interconnect_slave_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_interconnect_slave_arbiter.sv
// Per-slave-port AHB3-Lite arbiter: round-robin among masters at the top priority level,
// registered one-hot grant held across bursts/locks/wait states, plus data-phase owner tracking.
module ahb3lite_interconnect_slave_arbiter #(
    parameter  int MASTERS       = 3,
    localparam int PRIORITY_BITS = (MASTERS > 1) ? $clog2(MASTERS) : 1,
    localparam int IDX_BITS      = (MASTERS > 1) ? $clog2(MASTERS) : 1
) (
    input  logic                                   HCLK,
    input  logic                                   HRESETn,
    input  logic [MASTERS-1:0]                     HSEL,
    input  logic [MASTERS-1:0][PRIORITY_BITS-1:0]  priority_i,
    input  logic [PRIORITY_BITS-1:0]               priority_max,
    input  logic [MASTERS-1:0][1:0]                HTRANS,
    input  logic [MASTERS-1:0]                     HMASTLOCK,
    input  logic                                   HREADY,
    output logic [MASTERS-1:0]                     gnt,
    output logic [IDX_BITS-1:0]                    gnt_idx,
    output logic                                   gnt_valid,
    output logic [IDX_BITS-1:0]                    dphase_idx,
    output logic                                   dphase_valid
);

    localparam logic [IDX_BITS-1:0] LAST_IDX    = IDX_BITS'(MASTERS - 1);
    localparam logic [IDX_BITS:0]   MASTERS_W   = (IDX_BITS + 1)'(MASTERS);
    localparam logic [1:0]          HTRANS_BUSY = 2'b01;
    localparam logic [1:0]          HTRANS_SEQ  = 2'b11;

    logic [MASTERS-1:0]  gnt_q, gnt_d;
    logic [IDX_BITS-1:0] gnt_idx_q, gnt_idx_d;
    logic                gnt_valid_q, gnt_valid_d;
    logic [IDX_BITS-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_BITS-1:0] dphase_idx_q, dphase_idx_d;
    logic                dphase_valid_q, dphase_valid_d;

    logic [MASTERS-1:0]  eligible;
    logic                owner_busy;
    logic                can_switch;
    logic                pick_found;
    logic [IDX_BITS-1:0] pick_idx;
    logic [IDX_BITS:0]   cand;

    // The priority tree already resolved the maximum; only the ties matter here.
    generate
        for (genvar gi = 0; gi < MASTERS; gi++) begin : g_elig
            assign eligible[gi] = HSEL[gi] & (priority_i[gi] == priority_max);
        end
    endgenerate

    assign owner_busy = gnt_valid_q & HSEL[gnt_idx_q] &
                        (HMASTLOCK[gnt_idx_q] |
                         (HTRANS[gnt_idx_q] == HTRANS_SEQ) |
                         (HTRANS[gnt_idx_q] == HTRANS_BUSY));
    assign can_switch = HREADY & ~owner_busy;

    // Search upward from the master after the last winner, wrapping modulo MASTERS.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= MASTERS; k++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_BITS + 1)'(k);
            if (cand >= MASTERS_W) begin
                cand = cand - MASTERS_W;
            end
            if (!pick_found && eligible[cand[IDX_BITS-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IDX_BITS-1:0];
            end
        end
    end

    always_comb begin
        gnt_d          = gnt_q;
        gnt_idx_d      = gnt_idx_q;
        gnt_valid_d    = gnt_valid_q;
        rr_ptr_d       = rr_ptr_q;
        dphase_idx_d   = dphase_idx_q;
        dphase_valid_d = dphase_valid_q;

        if (can_switch) begin
            gnt_d = '0;
            if (pick_found) begin
                gnt_d[pick_idx] = 1'b1;
                gnt_idx_d       = pick_idx;
                gnt_valid_d     = 1'b1;
                rr_ptr_d        = pick_idx;
            end else begin
                gnt_valid_d     = 1'b0;
            end
        end

        // The address phase completing on this edge becomes the data phase.
        if (HREADY) begin
            dphase_idx_d   = gnt_idx_q;
            dphase_valid_d = gnt_valid_q & HSEL[gnt_idx_q] & HTRANS[gnt_idx_q][1];
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gnt_q          <= '0;
            gnt_idx_q      <= '0;
            gnt_valid_q    <= 1'b0;
            rr_ptr_q       <= LAST_IDX;
            dphase_idx_q   <= '0;
            dphase_valid_q <= 1'b0;
        end else begin
            gnt_q          <= gnt_d;
            gnt_idx_q      <= gnt_idx_d;
            gnt_valid_q    <= gnt_valid_d;
            rr_ptr_q       <= rr_ptr_d;
            dphase_idx_q   <= dphase_idx_d;
            dphase_valid_q <= dphase_valid_d;
        end
    end

    assign gnt          = gnt_q;
    assign gnt_idx      = gnt_idx_q;
    assign gnt_valid    = gnt_valid_q;
    assign dphase_idx   = dphase_idx_q;
    assign dphase_valid = dphase_valid_q;

endmodule

// File: tb/tb_ahb3lite_interconnect_slave_arbiter.sv
// Bench for the slave-port arbiter: directed vector table, hand-written multi-cycle
// sequences, and randomized traffic against a rule-level reference model.
module tb_ahb3lite_interconnect_slave_arbiter;

    localparam int M = 3;

    logic            HCLK;
    logic            HRESETn;
    logic [M-1:0]    HSEL;
    logic [M-1:0][1:0] priority_i;
    logic [1:0]      priority_max;
    logic [M-1:0][1:0] HTRANS;
    logic [M-1:0]    HMASTLOCK;
    logic            HREADY;
    logic [M-1:0]    gnt;
    logic [1:0]      gnt_idx;
    logic            gnt_valid;
    logic [1:0]      dphase_idx;
    logic            dphase_valid;

    int n_cmp = 0;
    int n_bad = 0;

    ahb3lite_interconnect_slave_arbiter #(.MASTERS(M)) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HSEL         (HSEL),
        .priority_i   (priority_i),
        .priority_max (priority_max),
        .HTRANS       (HTRANS),
        .HMASTLOCK    (HMASTLOCK),
        .HREADY       (HREADY),
        .gnt          (gnt),
        .gnt_idx      (gnt_idx),
        .gnt_valid    (gnt_valid),
        .dphase_idx   (dphase_idx),
        .dphase_valid (dphase_valid)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Reference model: owner as a plain integer, -1 meaning "no grant".
    int m_owner;
    int m_last_idx;
    int m_rr;
    int m_dpi;
    bit m_dpv;

    task automatic model_reset();
        m_owner    = -1;
        m_last_idx = 0;
        m_rr       = M - 1;
        m_dpi      = 0;
        m_dpv      = 0;
    endtask

    task automatic model_edge();
        bit busy;
        int winner;
        busy = 0;
        if (m_owner >= 0 && HSEL[m_owner] &&
            (HMASTLOCK[m_owner] || HTRANS[m_owner] == 2'd1 || HTRANS[m_owner] == 2'd3))
            busy = 1;
        if (HREADY) begin
            m_dpi = m_last_idx;
            m_dpv = (m_owner >= 0) && HSEL[m_owner] && (HTRANS[m_owner] >= 2'd2);
        end
        if (HREADY && !busy) begin
            winner = -1;
            for (int k = 1; k <= M; k++) begin
                int c;
                c = (m_rr + k) % M;
                if (winner < 0 && HSEL[c] && priority_i[c] == priority_max) winner = c;
            end
            m_owner = winner;
            if (winner >= 0) begin
                m_last_idx = winner;
                m_rr       = winner;
            end
        end
    endtask

    function automatic logic [M-1:0] model_gnt();
        logic [M-1:0] g;
        g = '0;
        if (m_owner >= 0) g[m_owner] = 1'b1;
        return g;
    endfunction

    task automatic cmp(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, got, want);
        end
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".gnt"},          int'(gnt),          int'(model_gnt()));
        cmp({tag, ".gnt_valid"},    int'(gnt_valid),    int'(m_owner >= 0));
        cmp({tag, ".gnt_idx"},      int'(gnt_idx),      m_last_idx);
        cmp({tag, ".dphase_valid"}, int'(dphase_valid), int'(m_dpv));
        cmp({tag, ".dphase_idx"},   int'(dphase_idx),   m_dpi);
    endtask

    // One clock: model follows the edge, outputs are sampled on the falling edge.
    task automatic step(input string tag);
        @(posedge HCLK);
        model_edge();
        @(negedge HCLK);
        check_model(tag);
        $display("[%0t] %s hsel=%b htrans=%h lock=%b hready=%b -> gnt=%b idx=%0d dp=%0d/%0d",
                 $time, tag, HSEL, HTRANS, HMASTLOCK, HREADY, gnt, gnt_idx, dphase_valid, dphase_idx);
    endtask

    task automatic drive(input logic [M-1:0] hsel, input logic [M-1:0][1:0] prio,
                         input logic [1:0] pmax, input logic [M-1:0][1:0] htrans,
                         input logic [M-1:0] lock, input logic hready);
        HSEL = hsel; priority_i = prio; priority_max = pmax;
        HTRANS = htrans; HMASTLOCK = lock; HREADY = hready;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        model_reset();
        repeat (2) @(negedge HCLK);
        cmp("reset.gnt",          int'(gnt),          0);
        cmp("reset.gnt_valid",    int'(gnt_valid),    0);
        cmp("reset.gnt_idx",      int'(gnt_idx),      0);
        cmp("reset.dphase_valid", int'(dphase_valid), 0);
        cmp("reset.dphase_idx",   int'(dphase_idx),   0);
        HRESETn = 1'b1;
    endtask

    typedef struct {
        logic [M-1:0]      hsel;
        logic [M-1:0][1:0] prio;
        logic [1:0]        pmax;
        logic [M-1:0][1:0] htrans;
        logic [M-1:0]      lock;
        logic              hready;
        logic [M-1:0]      exp_gnt;
        logic              exp_dpv;
        logic [1:0]        exp_dpi;
    } vec_t;

    vec_t tbl[11];

    initial begin
        // Packed arrays list master 2 first: {m2, m1, m0}.
        tbl[0]  = '{3'b010, {2'd0,2'd0,2'd0}, 2'd0, {2'd0,2'd2,2'd0}, 3'b000, 1'b1, 3'b010, 1'b0, 2'd0};
        tbl[1]  = '{3'b010, {2'd0,2'd0,2'd0}, 2'd0, {2'd0,2'd2,2'd0}, 3'b000, 1'b1, 3'b010, 1'b1, 2'd1};
        tbl[2]  = '{3'b111, {2'd2,2'd3,2'd1}, 2'd3, {2'd2,2'd2,2'd2}, 3'b000, 1'b1, 3'b010, 1'b1, 2'd1};
        tbl[3]  = '{3'b111, {2'd2,2'd3,2'd1}, 2'd3, {2'd2,2'd2,2'd2}, 3'b000, 1'b1, 3'b010, 1'b1, 2'd1};
        tbl[4]  = '{3'b111, {2'd0,2'd0,2'd0}, 2'd0, {2'd2,2'd2,2'd2}, 3'b000, 1'b1, 3'b100, 1'b1, 2'd1};
        tbl[5]  = '{3'b111, {2'd0,2'd0,2'd0}, 2'd0, {2'd2,2'd2,2'd2}, 3'b000, 1'b1, 3'b001, 1'b1, 2'd2};
        tbl[6]  = '{3'b111, {2'd0,2'd0,2'd0}, 2'd0, {2'd2,2'd2,2'd2}, 3'b000, 1'b1, 3'b010, 1'b1, 2'd0};
        tbl[7]  = '{3'b111, {2'd0,2'd0,2'd0}, 2'd0, {2'd2,2'd2,2'd2}, 3'b000, 1'b0, 3'b010, 1'b1, 2'd0};
        tbl[8]  = '{3'b111, {2'd0,2'd0,2'd0}, 2'd0, {2'd2,2'd2,2'd2}, 3'b000, 1'b1, 3'b100, 1'b1, 2'd1};
        tbl[9]  = '{3'b000, {2'd0,2'd0,2'd0}, 2'd0, {2'd0,2'd0,2'd0}, 3'b000, 1'b1, 3'b000, 1'b0, 2'd2};
        tbl[10] = '{3'b000, {2'd0,2'd0,2'd0}, 2'd0, {2'd0,2'd0,2'd0}, 3'b000, 1'b1, 3'b000, 1'b0, 2'd2};

        HRESETn = 1'b0;
        drive('0, '0, '0, '0, '0, 1'b1);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].hsel, tbl[i].prio, tbl[i].pmax, tbl[i].htrans, tbl[i].lock, tbl[i].hready);
            step($sformatf("vec%0d", i));
            cmp($sformatf("vec%0d.tbl_gnt", i), int'(gnt),          int'(tbl[i].exp_gnt));
            cmp($sformatf("vec%0d.tbl_dpv", i), int'(dphase_valid), int'(tbl[i].exp_dpv));
            cmp($sformatf("vec%0d.tbl_dpi", i), int'(dphase_idx),   int'(tbl[i].exp_dpi));
        end

        // Burst hold: master 0 bursts while master 2 waits at a higher level.
        do_reset();
        drive(3'b001, {2'd0,2'd0,2'd0}, 2'd0, {2'd0,2'd0,2'd2}, 3'b000, 1'b1);
        step("burst.start");
        cmp("burst.own", int'(gnt), 3'b001);
        for (int b = 0; b < 3; b++) begin
            drive(3'b101, {2'd1,2'd0,2'd0}, 2'd1, {2'd2,2'd0,2'd3}, 3'b000, 1'b1);
            step($sformatf("burst.seq%0d", b));
            cmp($sformatf("burst.hold%0d", b), int'(gnt), 3'b001);
        end
        drive(3'b101, {2'd1,2'd0,2'd0}, 2'd1, {2'd2,2'd0,2'd0}, 3'b000, 1'b1);
        step("burst.end");
        cmp("burst.switch", int'(gnt), 3'b100);

        // Locked master 1 across wait states.
        do_reset();
        drive(3'b010, {2'd0,2'd0,2'd0}, 2'd0, {2'd0,2'd2,2'd0}, 3'b010, 1'b1);
        step("lock.grant");
        cmp("lock.own", int'(gnt), 3'b010);
        drive(3'b111, {2'd0,2'd0,2'd0}, 2'd0, {2'd2,2'd2,2'd2}, 3'b010, 1'b1);
        step("lock.dphase");
        cmp("lock.dpi", int'(dphase_idx), 1);
        for (int w = 0; w < 3; w++) begin
            HREADY = (w == 2);
            step($sformatf("lock.wait%0d", w));
            cmp($sformatf("lock.gnt%0d", w), int'(gnt), 3'b010);
            cmp($sformatf("lock.dpi%0d", w), int'(dphase_idx), 1);
        end
        HMASTLOCK = 3'b000;
        step("lock.release");
        cmp("lock.switch", int'(gnt), 3'b100);

        // Asynchronous reset in the middle of a cycle while master 2 owns.
        @(negedge HCLK);
        #2 HRESETn = 1'b0;
        model_reset();
        #1;
        cmp("areset.gnt",          int'(gnt),          0);
        cmp("areset.dphase_valid", int'(dphase_valid), 0);
        @(negedge HCLK);
        HRESETn = 1'b1;
        drive(3'b101, {2'd0,2'd0,2'd0}, 2'd0, {2'd2,2'd2,2'd2}, 3'b000, 1'b1);
        step("areset.after");
        cmp("areset.first", int'(gnt), 3'b001);

        // Randomized traffic; priority_max normally reflects the true maximum.
        for (int n = 0; n < 400; n++) begin
            logic [M-1:0]      hs;
            logic [M-1:0][1:0] pr;
            logic [M-1:0][1:0] ht;
            logic [1:0]        pm;
            hs = M'($urandom);
            pr = (2 * M)'($urandom);
            ht = (2 * M)'($urandom);
            pm = 2'd0;
            for (int i = 0; i < M; i++)
                if (hs[i] && pr[i] > pm) pm = pr[i];
            if ($urandom_range(0, 7) == 0) pm = 2'($urandom);
            drive(hs, pr, pm, ht, ($urandom_range(0, 7) == 0) ? M'($urandom) : '0,
                  ($urandom_range(0, 3) != 0));
            step($sformatf("rand%0d", n));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
